// File: rtl/instr_sequencer.sv
// Multicycle fetch/load/execute sequencer for the single-issue core.
// Owns the program counter, jumps and halt; the datapath decodes ir on exec_en.
`timescale 1ns / 1ps

module instr_sequencer #(
    parameter int PC_W  = 5,
    parameter int DELAY = 2
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            stall,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            exec_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_HLT = 5'b11111;
    localparam int         CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       ir_op;
    logic [4:0]       rd_op;
    logic             rd_is_dp;

    assign ir_op     = ir[31:27];
    assign rd_op     = imem_rdata[31:27];
    assign rd_is_dp  = (rd_op != OP_JMP) && (rd_op != OP_HLT);
    assign imem_addr = pc;

    // stall is sampled on the edge that enters (or re-enters) EXEC, which keeps
    // exec_en a pure register while still honouring the datapath's busy signal.
    // NOTE: all state here is written with <= so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            wait_cnt    <= '0;
            imem_rd_en  <= 1'b0;
            exec_en     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pc          <= '0;
                        instr_count <= '0;
                        imem_rd_en  <= 1'b1;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state      <= S_LOAD;
                    imem_rd_en <= 1'b0;
                end
                S_LOAD: begin
                    ir      <= imem_rdata;
                    state   <= S_EXEC;
                    exec_en <= rd_is_dp && !stall;
                end
                S_EXEC: begin
                    if (ir_op == OP_HLT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (ir_op == OP_JMP) begin
                        state <= S_NEXT;
                    end else if (exec_en) begin
                        exec_en <= 1'b0;
                        if (DELAY > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= CNT_W'(DELAY - 1);
                        end else begin
                            state <= S_NEXT;
                        end
                    end else begin
                        exec_en <= !stall;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= S_NEXT;
                    else                wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_NEXT: begin
                    pc <= (ir_op == OP_JMP) ? ir[PC_W-1:0] : pc + PC_W'(1);
                    if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    state      <= S_FETCH;
                    imem_rd_en <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level interpreter predicts
// fetches, execute strobes and halts; a negedge monitor pops and compares.
`timescale 1ns / 1ps

module tb_instr_sequencer;

    localparam int         PC_W   = 5;
    localparam int         DELAY  = 2;
    localparam int         DEPTH  = 1 << PC_W;
    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_HLT = 5'b11111;

    logic            clk = 1'b0;
    logic            sys_rst, start, stall;
    logic            imem_rd_en, exec_en, busy, halted;
    logic [PC_W-1:0] imem_addr, pc;
    logic [31:0]     imem_rdata = '0;
    logic [31:0]     ir;
    logic [15:0]     instr_count;

    logic [31:0] mem [DEPTH];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          strict = 1'b1;
    bit          prev_exec = 1'b0;
    bit          prev_halt = 1'b0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     ir;
        logic [15:0]     cnt;
        int              cyc;
        bit              timed;
    } exec_t;
    typedef struct {
        logic [PC_W-1:0] pc;
        int              cyc;
        bit              timed;
    } fetch_t;
    typedef struct {
        logic [PC_W-1:0] pc;
        logic [15:0]     cnt;
        int              cyc;
        bit              timed;
    } halt_t;

    exec_t  exec_q[$];
    fetch_t fetch_q[$];
    halt_t  halt_q[$];

    instr_sequencer #(.PC_W(PC_W), .DELAY(DELAY)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .stall      (stall),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .exec_en    (exec_en),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen with nothing required (cycle %0d)", name, cyc);
    endtask

    function automatic int pending();
        return exec_q.size() + fetch_q.size() + halt_q.size();
    endfunction

    // Program-level interpreter: walks memory from pc 0 using the ISA rules and
    // the per-instruction cycle costs, recording what the DUT must show.
    task automatic build_expect(input int t0, input bit timed, input int first_stall,
                                input int max_steps);
        logic [PC_W-1:0] p = '0;
        logic [15:0]     c = '0;
        logic [31:0]     w;
        int              t = t0;
        int              s;
        for (int step = 0; step < max_steps; step++) begin
            w = mem[p];
            fetch_q.push_back('{p, t, timed});
            if (w[31:27] == OP_HLT) begin
                halt_q.push_back('{p, c, t + 3, timed});
                return;
            end
            if (w[31:27] == OP_JMP) begin
                t += 4;
                p = w[PC_W-1:0];
            end else begin
                s = (step == 0) ? first_stall : 0;
                exec_q.push_back('{p, w, c, t + 2 + s, timed});
                t += 4 + DELAY + s;
                p = PC_W'((int'(p) + 1) % DEPTH);
            end
            c = (c == 16'hFFFF) ? c : c + 16'd1;
        end
    endtask

    always @(negedge clk) begin
        exec_t  e;
        fetch_t f;
        halt_t  h;
        if (!sys_rst) begin
            prev_exec <= 1'b0;
            prev_halt <= 1'b0;
        end else begin
            if (exec_en) begin
                check("exec_en_back_to_back", 64'(prev_exec), 64'(0));
                if (exec_q.size() > 0) begin
                    e = exec_q.pop_front();
                    check("exec_pc", 64'(pc), 64'(e.pc));
                    check("exec_ir", 64'(ir), 64'(e.ir));
                    check("exec_count", 64'(instr_count), 64'(e.cnt));
                    if (e.timed) check("exec_cycle", 64'(cyc), 64'(e.cyc));
                end else if (strict) report_unexpected("exec_en");
            end
            if (imem_rd_en) begin
                if (fetch_q.size() > 0) begin
                    f = fetch_q.pop_front();
                    check("fetch_addr", 64'(imem_addr), 64'(f.pc));
                    if (f.timed) check("fetch_cycle", 64'(cyc), 64'(f.cyc));
                end else if (strict) report_unexpected("fetch");
            end
            if (halted && !prev_halt) begin
                if (halt_q.size() > 0) begin
                    h = halt_q.pop_front();
                    check("halt_pc", 64'(pc), 64'(h.pc));
                    check("halt_count", 64'(instr_count), 64'(h.cnt));
                    check("halt_busy", 64'(busy), 64'(0));
                    check("halt_leftover_exec", 64'(exec_q.size()), 64'(0));
                    if (h.timed) check("halt_cycle", 64'(cyc), 64'(h.cyc));
                end else if (strict) report_unexpected("halt");
            end
            prev_exec <= exec_en;
            prev_halt <= halted;
        end
    end

    task automatic start_run(input bit timed, input int first_stall, input int max_steps);
        @(negedge clk);
        start = 1'b1;
        build_expect(cyc + 1, timed, first_stall, max_steps);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_stall);
        for (int i = 0; i < budget && pending() > 0; i++) begin
            @(negedge clk);
            if (rnd_stall) stall = ($urandom_range(0, 2) == 0);
        end
        stall = 1'b0;
        check("scoreboard_drained", 64'(pending()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        exec_q.delete();
        fetch_q.delete();
        halt_q.delete();
        @(negedge clk);
        sys_rst = 1'b1;
    endtask

    function automatic logic [31:0] dp_op(input logic [4:0] op, input logic [26:0] rest);
        return {op, rest};
    endfunction

    task automatic gen_random_program();
        int          last;
        logic [31:0] r;
        logic [4:0]  op;
        last = $urandom_range(2, DEPTH - 1);
        for (int p = 0; p < DEPTH; p++) begin
            r  = $urandom();
            op = 5'($urandom_range(0, 23));
            if (p == last) mem[p] = {OP_HLT, r[26:0]};
            else if (p < last && $urandom_range(0, 4) == 0)
                mem[p] = {OP_JMP, r[26:PC_W], PC_W'($urandom_range(p + 1, last))};
            else mem[p] = dp_op(op, r[26:0]);
        end
    endtask

    initial begin
        bit found;
        sys_rst = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {OP_HLT, 27'd0};

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({imem_rd_en, exec_en, busy, halted, imem_addr, pc, ir, instr_count}), 64'(0));
        sys_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", 64'({imem_rd_en, exec_en, busy, halted, imem_addr, pc, ir, instr_count}), 64'(0));
        end

        // Straight-line program: ADI, MOV, HLT
        mem[0] = {5'd2, 5'd0, 5'd2, 1'b1, 16'd4};
        mem[1] = {5'd1, 5'd3, 5'd1, 1'b0, 5'd0, 11'd0};
        mem[2] = {OP_HLT, 27'd0};
        start_run(1'b1, 0, 64);
        wait_done(200, 1'b0);
        check("straight_pc", 64'(pc), 64'(2));
        check("straight_count", 64'(instr_count), 64'(2));

        // Stall held for three EXEC cycles on an ADD
        mem[0] = {5'd0, 5'd1, 5'd2, 1'b0, 5'd3, 11'd0};
        mem[1] = {OP_HLT, 27'd0};
        start_run(1'b1, 3, 64);
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_done(200, 1'b0);

        // Jump from the top of memory, target taken from isrc low bits
        mem[0]  = {OP_JMP, 11'h155, 16'd31};
        mem[31] = {OP_JMP, 11'h2AA, 16'hFFE3};
        mem[3]  = {OP_HLT, 27'd0};
        start_run(1'b1, 0, 64);
        wait_done(200, 1'b0);
        check("jump_pc", 64'(pc), 64'(3));
        check("jump_count", 64'(instr_count), 64'(2));

        // Datapath op at the top of memory wraps pc to 0 (endless loop, then reset)
        mem[31] = {5'd3, 5'd4, 5'd5, 1'b1, 16'h0077};
        strict  = 1'b0;
        start_run(1'b1, 0, 6);
        wait_done(200, 1'b0);
        do_reset();
        strict = 1'b1;

        // Random programs; the first also checks start masking and restart
        for (int r = 0; r < 4; r++) begin
            gen_random_program();
            start_run(r == 0, 0, 64);
            if (r == 0) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(3000, r != 0);
            if (r == 0) begin
                start_run(1'b1, 0, 64);
                check("restart_pc", 64'(pc), 64'(0));
                check("restart_count", 64'(instr_count), 64'(0));
                check("restart_busy", 64'({busy, halted}), 64'(2'b10));
                wait_done(3000, 1'b0);
            end
        end

        // Asynchronous reset during the second instruction's EXEC
        mem[0] = {5'd0, 5'd1, 5'd2, 1'b0, 5'd3, 11'd0};
        mem[1] = {5'd4, 5'd2, 5'd3, 1'b1, 16'h1234};
        mem[2] = {5'd5, 5'd3, 5'd4, 1'b0, 5'd5, 11'd0};
        mem[3] = {OP_HLT, 27'd0};
        start_run(1'b1, 0, 64);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = exec_en && (pc == PC_W'(1));
        end
        check("reached_exec", 64'(found), 64'(1));
        #1 sys_rst = 1'b0;
        #1;
        check("async_exec_en", 64'(exec_en), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_pc", 64'(pc), 64'(0));
        check("async_ir", 64'(ir), 64'(0));
        check("async_count_halted", 64'({instr_count, halted}), 64'(0));
        exec_q.delete();
        fetch_q.delete();
        halt_q.delete();
        @(negedge clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 64'({imem_rd_en, exec_en, busy, halted}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multicycle control FSM for the single-issue processor. It fetches 32-bit instructions from a synchronous program memory and latches them into the instruction register (IR). It issues a one-cycle execute strobe to the GPR/ALU datapath, which decodes imm_mode, oper_type, rsrc1, rsrc2, rdst and isrc from the IR. The sequencer itself handles only program-counter updates, jumps and halt.

## Interface
- PC_W, 5, program-counter width; program memory depth is 2^PC_W words
- DELAY, 2, idle cycles inserted after each execute strobe (0 allowed)
- clk  in  1  system clock, rising edge
- sys_rst  in  1  asynchronous, active-low reset; single clock domain
- start  in  1  begin execution at PC 0; sampled only in IDLE or HALT
- stall  in  1  datapath busy; holds the sequencer in EXEC
- imem_rd_en  out  1  program-memory read enable
- imem_addr  out  PC_W  program-memory address; equals pc
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en
- ir  out  32  registered instruction; decode fields [31:27] oper_type, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:11] rsrc2, [15:0] isrc
- exec_en  out  1  one-cycle pulse; datapath executes ir and writes back on this edge
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- instr_count  out  16  retired-instruction counter

## Operation
- Reset values: state IDLE; pc 0; ir 0; instr_count 0; imem_rd_en, exec_en, busy and halted all 0.
- Sequencer-owned opcodes:
  - oper_type 5'b11000 is JMP, with target isrc[PC_W-1:0].
  - oper_type 5'b11111 is HLT.
  - All other opcodes are datapath ops.
- IDLE:
  - start=1 -> FETCH, with pc cleared to 0 and instr_count cleared to 0.
- FETCH:
  - imem_rd_en=1 and imem_addr=pc.
  - -> LOAD unconditionally.
- LOAD:
  - ir <= imem_rdata.
  - -> EXEC.
- EXEC, by ir opcode:
  - HLT -> HALT. No exec_en, no count.
  - JMP -> NEXT. No exec_en.
  - Datapath op with stall=1: hold in EXEC, exec_en=0.
  - Datapath op with stall=0: exec_en=1 for exactly this cycle, then -> WAIT if DELAY>0, else -> NEXT.
- WAIT:
  - Down-counter loaded with DELAY-1 on entry.
  - Decrement each cycle; -> NEXT when the counter reads 0.
- NEXT:
  - pc <= target for JMP, else pc+1 modulo 2^PC_W (wraps from 2^PC_W-1 to 0).
  - instr_count += 1, saturating at 16'hFFFF.
  - -> FETCH.
- HALT:
  - pc and ir hold.
  - start=1 -> FETCH with pc and instr_count cleared, the same as from IDLE.
- start is ignored while busy=1.
- stall is ignored in every state except EXEC.
- ir changes only in LOAD, so the datapath sees a stable ir from LOAD+1 through NEXT.

## Timing
- Every output is registered or decoded purely from state; there is no combinational path from input to output.
- With stall=0, a datapath op occupies 4+DELAY cycles: FETCH, LOAD, EXEC, DELAY×WAIT, NEXT.
  - JMP occupies 4 cycles (it skips WAIT).
  - HLT occupies 3 cycles to HALT.
- Start latency: start sampled high at edge N gives FETCH during cycle N+1. The first exec_en is high in cycle N+3.
- Each cycle of stall adds one cycle in EXEC. exec_en rises in the first EXEC cycle with stall=0 and is never high for two consecutive cycles.
- Reset mid-operation: sys_rst low forces the reset values immediately, independent of clk. An in-flight exec_en is cancelled. After release, the sequencer waits in IDLE for start.
- Memory contract: imem_rdata is required valid during LOAD only.

## Test plan
- Reset and idle:
  - Stimulus: hold sys_rst low, then release with start=0 for 10 cycles.
  - Required: every output stays at its reset value and state stays IDLE.
- Straight-line program, DELAY=2:
  - Memory [0] ADI (imm_mode=1, oper_type=2, rsrc1=2, rdst=0, isrc=4), [1] MOV reg, [2] HLT; pulse start.
  - Required: exec_en pulses exactly twice, 6 cycles apart.
  - Required: halted=1 with pc=2 and instr_count=2.
- Stall:
  - Stimulus: ADD program; hold stall=1 for 3 cycles when EXEC is entered.
  - Required: exec_en stays 0 for 3 cycles, then pulses once; total instruction length is 9 cycles with DELAY=2.
- Jump and wrap:
  - Memory [31] JMP isrc=3 and [3] HLT, with PC_W=5; a second case with a non-JMP op at [31].
  - Required: after [31], pc becomes 3 and the sequencer halts there.
  - Required, second case: pc wraps from 31 to 0.
- Restart and start masking:
  - Stimulus: pulse start while busy; then pulse start while halted.
  - Required: the start while busy is ignored.
  - Required: the start while halted restarts from pc=0 with instr_count=0.
- Async reset mid-EXEC:
  - Stimulus: drop sys_rst between clock edges during EXEC.
  - Required: exec_en and busy fall immediately with no clock edge; pc=0 and ir=0.
